// File: rtl/recreg_bank.sv
// recreg_bank: double-buffered receive register bank, MAC fills one frame buffer while the CPU reads the other.
// release is a reserved word, so the CPU release strobe is the port rd_release.
module recreg_bank #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4,
   parameter int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               can,
   input  logic [AW-1:0]      widx,
   input  logic [WIDTH-1:0]   regin1,
   input  logic [WIDTH-1:0]   regin2,
   input  logic               frame_done,
   input  logic               frame_abort,
   input  logic [AW-1:0]      rd_idx,
   input  logic               rd_release,
   input  logic               ovr_clr,
   output logic [2*WIDTH-1:0] regout,
   output logic               rx_valid,
   output logic [1:0]         pending,
   output logic               overrun
);
   localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
   logic [1:0] state;
   logic wr_sel, rd_sel;
   logic [2*WIDTH-1:0] mem [2][WORDS];
   logic ab, wr, rel, com, drop;
   always_comb begin
      ab   = frame_abort && state != FULL;
      wr   = can && !ab && state != FULL && int'(widx) < WORDS;
      rel  = rd_release && state != EMPTY;
      com  = frame_done && !ab && state != FULL;
      drop = frame_done && state == FULL;
   end
   // state doubles as the committed-frame count
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= EMPTY;
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state + {1'b0, com} - {1'b0, rel};
         wr_sel  <= wr_sel ^ com;
         rd_sel  <= rd_sel ^ rel;
         overrun <= drop | (overrun & ~ovr_clr);
      end
   end
   // a released or aborted buffer is wiped so the next frame starts from zero
   always_ff @(posedge clk) begin
      for (int b = 0; b < 2; b++)
         for (int w = 0; w < WORDS; w++)
            if (!rst || (ab && b == int'(wr_sel)) || (rel && b == int'(rd_sel)))
               mem[b][w] <= '0;
            else if (wr && b == int'(wr_sel) && w == int'(widx))
               mem[b][w] <= {regin1, regin2};
   end
   always_comb regout = (state == EMPTY || int'(rd_idx) >= WORDS) ? '0 : mem[rd_sel][rd_idx];
   assign rx_valid = state != EMPTY;
   assign pending  = state;
endmodule

// File: tb/tb_recreg_bank.sv
// tb_recreg_bank: directed and random checks of recreg_bank against a frame-queue reference model.
module tb_recreg_bank;
   localparam int WORDS = 4;
   typedef logic [WORDS-1:0][15:0] frame_t;
   logic clk = 1'b0;
   logic rst = 1'b0, can = 1'b0, frame_done = 1'b0, frame_abort = 1'b0, rd_release = 1'b0, ovr_clr = 1'b0;
   logic [1:0] widx = '0, rd_idx = '0;
   logic [7:0] regin1 = '0, regin2 = '0;
   logic [15:0] regout;
   logic rx_valid, overrun;
   logic [1:0] pending;
   int errs = 0, checks = 0;
   frame_t q[$];
   frame_t fill = '0;
   logic ovr = 1'b0;

   recreg_bank dut (
      .clk(clk), .rst(rst), .can(can), .widx(widx), .regin1(regin1), .regin2(regin2),
      .frame_done(frame_done), .frame_abort(frame_abort), .rd_idx(rd_idx), .rd_release(rd_release),
      .ovr_clr(ovr_clr), .regout(regout), .rx_valid(rx_valid), .pending(pending), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock: drive inputs, advance the model by the frame rules, compare all outputs
   task automatic cyc(input logic r, input logic c, input logic [1:0] wi, input logic [15:0] d,
                      input logic fd, input logic fa, input logic rl, input logic oc, input logic [1:0] ri);
      int n;
      @(negedge clk);
      rst = r; can = c; widx = wi; {regin1, regin2} = d;
      frame_done = fd; frame_abort = fa; rd_release = rl; ovr_clr = oc; rd_idx = ri;
      @(posedge clk);
      if (!r) begin
         q.delete();
         fill = '0;
         ovr = 1'b0;
      end else begin
         n = q.size();
         if (fd && n == 2) ovr = 1'b1;
         else if (oc) ovr = 1'b0;
         if (n < 2) begin
            if (fa) fill = '0;
            else begin
               if (c && int'(wi) < WORDS) fill[wi] = d;
               if (fd) begin
                  q.push_back(fill);
                  fill = '0;
               end
            end
         end
         if (rl && n > 0) void'(q.pop_front());
      end
      #1;
      chk("pending", 32'(pending), 32'(q.size()));
      chk("rx_valid", 32'(rx_valid), 32'(q.size() > 0));
      chk("overrun", 32'(overrun), 32'(ovr));
      chk("regout", 32'(regout), q.size() > 0 ? 32'(q[0][ri]) : 32'd0);
   endtask

   task automatic peek(input string tag, input logic [1:0] i, input logic [15:0] exp);
      rd_idx = i;
      #1;
      chk(tag, 32'(regout), 32'(exp));
   endtask

   task automatic wr(input logic [1:0] wi, input logic [15:0] d, input logic fd, input logic rl);
      cyc(1'b1, 1'b1, wi, d, fd, 1'b0, rl, 1'b0, 2'd0);
   endtask

   task automatic reset_dut();
      cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   initial begin
      reset_dut();
      reset_dut();
      chk("reset_pending", 32'(pending), 32'd0);
      chk("reset_valid", 32'(rx_valid), 32'd0);
      // basic commit and readback
      wr(2'd0, 16'hABCD, 1'b0, 1'b0);
      wr(2'd3, 16'h1234, 1'b1, 1'b0);
      chk("commit_valid", 32'(rx_valid), 32'd1);
      chk("commit_pending", 32'(pending), 32'd1);
      peek("commit_w0", 2'd0, 16'hABCD);
      peek("commit_w3", 2'd3, 16'h1234);
      peek("commit_w1", 2'd1, 16'h0000);
      // overrun on third frame, then release
      reset_dut();
      wr(2'd0, 16'h1111, 1'b1, 1'b0);
      wr(2'd0, 16'h2222, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      chk("full_pending", 32'(pending), 32'd2);
      chk("full_overrun", 32'(overrun), 32'd1);
      peek("full_w0", 2'd0, 16'h1111);
      cyc(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      peek("rel_w0", 2'd0, 16'h2222);
      chk("rel_pending", 32'(pending), 32'd1);
      // overrun set beats clear, then clear alone
      wr(2'd1, 16'h3333, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
      chk("ovr_set_wins", 32'(overrun), 32'd1);
      cyc(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      chk("ovr_clear", 32'(overrun), 32'd0);
      // abort wins over done
      reset_dut();
      wr(2'd0, 16'h5555, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("abort_pending", 32'(pending), 32'd0);
      wr(2'd1, 16'h0001, 1'b1, 1'b0);
      peek("abort_w0", 2'd0, 16'h0000);
      peek("abort_w1", 2'd1, 16'h0001);
      // release and done with a write in the same cycle
      reset_dut();
      wr(2'd0, 16'h0001, 1'b1, 1'b0);
      wr(2'd0, 16'h7777, 1'b1, 1'b1);
      chk("reldone_pending", 32'(pending), 32'd1);
      peek("reldone_w0", 2'd0, 16'h7777);
      // reset mid-frame with simultaneous done
      wr(2'd2, 16'h9999, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 2'd2, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      peek("rst_regout", 2'd2, 16'h0000);
      wr(2'd0, 16'h4242, 1'b1, 1'b0);
      peek("rst_w2", 2'd2, 16'h0000);
      peek("rst_w0", 2'd0, 16'h4242);
      // random traffic
      for (int i = 0; i < 2000; i++)
         cyc($urandom_range(0, 99) >= 2, $urandom_range(0, 1) == 1, 2'($urandom), 16'($urandom),
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 10, 2'($urandom));
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/recreg_bank.md
RECREG_BANK -- requirements
Module: recreg_bank

Interface
REQ-001 Parameter WIDTH, default 8, width of each input half-word; output word is 2*WIDTH.
REQ-002 Parameter WORDS, default 4, 16-bit words per received frame; AW = max(1, clog2(WORDS)).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 can  in  1  MAC write strobe for one word.
REQ-006 widx  in  AW  MAC word index for the write.
REQ-007 regin1  in  WIDTH  MAC data, upper half of word.
REQ-008 regin2  in  WIDTH  MAC data, lower half of word.
REQ-009 frame_done  in  1  MAC commits the frame being filled.
REQ-010 frame_abort  in  1  MAC discards the frame being filled (error frame).
REQ-011 rd_idx  in  AW  CPU read word index.
REQ-012 release  in  1  CPU frees the frame it is reading.
REQ-013 ovr_clr  in  1  CPU clears overrun flag.
REQ-014 regout  out  2*WIDTH  word rd_idx of read buffer, combinational from registers.
REQ-015 rx_valid  out  1  read buffer holds a committed frame.
REQ-016 pending  out  2  committed frames held, 0..2.
REQ-017 overrun  out  1  sticky: a completed frame was dropped.

Function
REQ-018 Two frame buffers B0/B1, each WORDS x 2*WIDTH; pointer wr_sel selects fill buffer, rd_sel selects read buffer.
REQ-019 State machine EMPTY (pending=0), ONE (pending=1), FULL (pending=2); pending reflects state, registered.
REQ-020 EMPTY/ONE: can=1 and widx<WORDS writes {regin1,regin2} to fill buffer word widx at next edge; widx>=WORDS ignored.
REQ-021 FULL: can ignored, no buffer modified.
REQ-022 frame_done in EMPTY: commit, wr_sel toggles, -> ONE; in ONE: commit, wr_sel toggles, -> FULL.
REQ-023 frame_done in FULL: frame dropped, overrun=1 next cycle, state unchanged by frame_done.
REQ-024 can and frame_done same cycle: the write is part of the committed frame.
REQ-025 frame_abort (EMPTY/ONE): fill buffer zeroed next edge, no commit; frame_abort wins over frame_done and can in same cycle; in FULL no effect.
REQ-026 release in ONE: read buffer zeroed, rd_sel toggles, -> EMPTY; in FULL: zeroed, rd_sel toggles, -> ONE; in EMPTY ignored.
REQ-027 release and frame_done same cycle: ONE -> ONE (both rd_sel and wr_sel toggle); EMPTY -> ONE; FULL -> ONE with overrun=1.
REQ-028 rx_valid = (state != EMPTY); regout = 0 when rd_idx>=WORDS; when EMPTY regout reads the zeroed buffer, i.e. 0.
REQ-029 overrun cleared by ovr_clr; simultaneous set event and ovr_clr: set wins.
REQ-030 Data latency: committed frame readable on regout the cycle after frame_done edge.

Reset
REQ-031 rst=0 at edge: both buffers zero, state EMPTY, wr_sel=0, rd_sel=0, overrun=0; regout=0, rx_valid=0, pending=0 next cycle.
REQ-032 Reset overrides all inputs, including mid-frame writes and simultaneous frame_done.

Verification
REQ-033 Write widx0=AB/CD, widx3=12/34, frame_done -> rx_valid=1, pending=1, rd_idx0 regout=0xABCD, rd_idx3 0x1234, rd_idx1 0x0000.
REQ-034 Commit frames F1 (w0=0x1111), F2 (w0=0x2222), F3 done -> pending=2, overrun=1, regout=0x1111; release -> regout=0x2222, pending=1.
REQ-035 Write w0=0x5555, frame_abort+frame_done same cycle -> pending=0; next frame writes only w1=0x0001, commits -> w0 reads 0x0000.
REQ-036 In ONE, release+frame_done with can writing w0=0x7777 same cycle -> pending=1, regout(w0)=0x7777.
REQ-037 Mid-frame rst=0 after writing w2=0x9999 -> all outputs 0; subsequent frame with no w2 write reads w2=0x0000.
REQ-038 overrun=1, ovr_clr with FULL frame_done same cycle -> overrun remains 1; ovr_clr alone next cycle -> 0.
